// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the receiver, the RX FIFO and the APB register block.
package uart_pkg;

    localparam int unsigned UART_DATA_W        = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/axis_uart_rx_fifo_if.sv
// Byte-wide AXI-Stream handshake bundle: the producer holds the master modport, the consumer holds the slave modport.
interface axis_uart_rx_fifo_if #(
    parameter int unsigned DATA_W = uart_pkg::UART_DATA_W
);

    logic [DATA_W-1:0] data;
    logic              tvalid;
    logic              tready;

    modport master (
        output data,
        output tvalid,
        input  tready
    );

    modport slave (
        input  data,
        input  tvalid,
        output tready
    );

endinterface : axis_uart_rx_fifo_if

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, cleared to zero on reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int unsigned DATA_W = UART_DATA_W,
    parameter  int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : uart_fifo_mem

// File: rtl/axis_uart_rx_fifo.sv
// Receive byte buffer between the UART receiver and the bus-side consumer, with occupancy,
// threshold interrupt and sticky overflow reporting.
module axis_uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DATA_W = UART_DATA_W,
    parameter  int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    axis_uart_rx_fifo_if.slave  saxis,
    axis_uart_rx_fifo_if.master maxis,
    input  logic                flush_i,
    input  logic [AW:0]         thresh_i,
    output logic [AW:0]         level_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                thresh_irq_o,
    output logic                overflow_o
);

    localparam int unsigned LW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;

    logic          full;
    logic          empty;
    logic          s_ready;
    logic          wr_en;
    logic          rd_en;
    logic          ovf_set;

    // Flags decode from registered count; ready never depends on the consumer's tready.
    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign s_ready = ~full & ~flush_i;
    assign wr_en   = saxis.tvalid & s_ready;
    assign rd_en   = ~empty & maxis.tready & ~flush_i;
    assign ovf_set = saxis.tvalid & ~s_ready & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (ovf_set) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (saxis.data),
        .raddr (rd_ptr_q),
        .rdata (maxis.data)
    );

    assign saxis.tready = s_ready;
    assign maxis.tvalid = ~empty;

    assign level_o      = level_q;
    assign full_o       = full;
    assign empty_o      = empty;
    assign thresh_irq_o = (thresh_i != '0) && (level_q >= thresh_i);
    assign overflow_o   = ovf_q;

endmodule : axis_uart_rx_fifo

// File: tb/tb_axis_uart_rx_fifo.sv
// Directed self-checking bench for axis_uart_rx_fifo.
module tb_axis_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [4:0] thresh;
    logic [4:0] level;
    logic       full;
    logic       empty;
    logic       irq;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    axis_uart_rx_fifo_if #(.DATA_W(8)) s_if ();
    axis_uart_rx_fifo_if #(.DATA_W(8)) m_if ();

    axis_uart_rx_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .saxis        (s_if.slave),
        .maxis        (m_if.master),
        .flush_i      (flush),
        .thresh_i     (thresh),
        .level_o      (level),
        .full_o       (full),
        .empty_o      (empty),
        .thresh_irq_o (irq),
        .overflow_o   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        s_if.data   = b;
        s_if.tvalid = 1'b1;
        step();
        s_if.tvalid = 1'b0;
    endtask

    logic [7:0] q[$];
    logic [7:0] nb;

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        thresh      = 5'd0;
        s_if.data   = 8'h00;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;

        // Reset state
        #12;
        check("rst_level",  32'(level),       32'd0);
        check("rst_empty",  32'(empty),       32'd1);
        check("rst_full",   32'(full),        32'd0);
        check("rst_sready", 32'(s_if.tready), 32'd1);
        check("rst_mvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_mdata",  32'(m_if.data),   32'h00);
        check("rst_irq",    32'(irq),         32'd0);
        check("rst_ovf",    32'(ovf),         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_level", 32'(level), 32'd0);

        // Two writes with consumer stalled, then two reads
        push(8'hA5);
        check("lat_mvalid", 32'(m_if.tvalid), 32'd1);
        check("lat_mdata",  32'(m_if.data),   32'hA5);
        push(8'h3C);
        check("two_level",  32'(level),       32'd2);
        check("two_head",   32'(m_if.data),   32'hA5);
        m_if.tready = 1'b1;
        check("rd0_data",   32'(m_if.data),   32'hA5);
        step();
        check("rd1_data",   32'(m_if.data),   32'h3C);
        step();
        m_if.tready = 1'b0;
        check("rd_empty",   32'(empty),       32'd1);
        check("rd_mvalid",  32'(m_if.tvalid), 32'd0);

        // Fill to DEPTH, then refused write sets overflow
        for (int i = 0; i < 16; i++) push(8'(i));
        check("fill_level",  32'(level),       32'd16);
        check("fill_full",   32'(full),        32'd1);
        check("fill_sready", 32'(s_if.tready), 32'd0);
        check("fill_ovf0",   32'(ovf),         32'd0);
        s_if.data   = 8'hFF;
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        #1;
        check("full_rw_sready", 32'(s_if.tready), 32'd0);
        step();
        s_if.tvalid = 1'b0;
        check("ovf_set",     32'(ovf),   32'd1);
        check("ovf_level",   32'(level), 32'd15);
        check("ovf_head",    32'(m_if.data), 32'h01);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain%0d", i), 32'(m_if.data), 32'(i));
            step();
        end
        m_if.tready = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("ovf_sticky",  32'(ovf),   32'd1);

        // Level 5 then 40 cycles of concurrent write+read
        for (int i = 0; i < 5; i++) begin
            push(8'h10 + 8'(i));
            q.push_back(8'h10 + 8'(i));
        end
        check("l5_level", 32'(level), 32'd5);
        m_if.tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            nb          = 8'h20 + 8'(i);
            s_if.data   = nb;
            s_if.tvalid = 1'b1;
            check($sformatf("rw%0d_data", i), 32'(m_if.data), 32'(q.pop_front()));
            q.push_back(nb);
            step();
            check($sformatf("rw%0d_level", i), 32'(level), 32'd5);
        end
        s_if.tvalid = 1'b0;
        while (q.size() > 0) begin
            check("rw_tail", 32'(m_if.data), 32'(q.pop_front()));
            step();
        end
        m_if.tready = 1'b0;
        check("rw_empty", 32'(empty), 32'd1);

        // Threshold interrupt
        thresh = 5'd4;
        for (int i = 0; i < 3; i++) push(8'h50 + 8'(i));
        check("th_l3_irq", 32'(irq), 32'd0);
        push(8'h53);
        check("th_l4_irq", 32'(irq), 32'd1);
        m_if.tready = 1'b1;
        step();
        m_if.tready = 1'b0;
        check("th_rd_level", 32'(level), 32'd3);
        check("th_rd_irq",   32'(irq),   32'd0);
        thresh = 5'd0;
        for (int i = 0; i < 4; i++) begin
            push(8'h60 + 8'(i));
            check($sformatf("th0_irq%0d", i), 32'(irq), 32'd0);
        end
        check("l7_level", 32'(level), 32'd7);
        check("l7_ovf",   32'(ovf),   32'd1);

        // Flush wins over concurrent write and read
        flush       = 1'b1;
        s_if.data   = 8'hEE;
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        #1;
        check("fl_sready", 32'(s_if.tready), 32'd0);
        step();
        flush       = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        check("fl_level",  32'(level),       32'd0);
        check("fl_ovf",    32'(ovf),         32'd0);
        check("fl_empty",  32'(empty),       32'd1);
        check("fl_mvalid", 32'(m_if.tvalid), 32'd0);
        push(8'h42);
        check("pf_level", 32'(level),     32'd1);
        check("pf_data",  32'(m_if.data), 32'h42);

        // Asynchronous reset mid-transfer
        push(8'h43);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_level", 32'(level),       32'd0);
        check("ar_data",  32'(m_if.data),   32'h00);
        check("ar_empty", 32'(empty),       32'd1);
        check("ar_sready",32'(s_if.tready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_axis_uart_rx_fifo

// File: doc/axis_uart_rx_fifo.md
# axis_uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver's AXI-Stream master port. It accepts received bytes on an AXIS slave port, stores up to DEPTH of them, and presents them in order on an AXIS master port to the bus-side consumer (APB read logic or DMA). The receiver does not tolerate backpressure, so the block also reports occupancy, a programmable fill threshold and a sticky overflow (stall) indication.

## Interface
- DATA_W, 8, byte width; must equal the receiver data width
- DEPTH, 16, number of entries; power of two, ≥ 2
- AW, $clog2(DEPTH), pointer width (derived, not overridden)

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- saxis_data_i  in  DATA_W  byte from the receiver
- saxis_tvalid_i  in  1  byte valid
- saxis_tready_o  out  1  FIFO can accept
- maxis_data_o  out  DATA_W  head-of-FIFO byte
- maxis_tvalid_o  out  1  FIFO not empty
- maxis_tready_i  in  1  consumer accepts head byte
- flush_i  in  1  synchronous clear, one-cycle pulse or level
- thresh_i  in  AW+1  fill threshold; 0 disables thresh_irq_o
- level_o  out  AW+1  current occupancy, 0..DEPTH
- full_o  out  1  level_o == DEPTH
- empty_o  out  1  level_o == 0
- thresh_irq_o  out  1  level_o ≥ thresh_i and thresh_i ≠ 0
- overflow_o  out  1  sticky: a write was refused

## Operation
- Storage: DEPTH × DATA_W array, write pointer wr_ptr, read pointer rd_ptr (AW bits, natural wrap), registered count level (AW+1 bits).
- Write: saxis_tvalid_i && saxis_tready_o → mem[wr_ptr] ← data, wr_ptr+1.
- Read: maxis_tvalid_o && maxis_tready_i → rd_ptr+1.
- level: +1 on write only, −1 on read only, unchanged on both or neither.
- saxis_tready_o = ~full_o & ~flush_i. No combinational path from maxis_tready_i to saxis_tready_o: when full, a write is refused even if a read occurs in the same cycle.
- maxis_tvalid_o = ~empty_o; maxis_data_o = mem[rd_ptr]. Data is held stable while tvalid is high and tready is low.
- overflow_o sets on any cycle with saxis_tvalid_i=1 and saxis_tready_o=0 and flush_i=0. It stays set until flush_i or reset.
- flush_i has the highest priority. In that cycle it clears wr_ptr, rd_ptr, level and overflow_o, and ignores any write or read.
- Reset: pointers 0, level 0, mem all 0. Outputs during and after reset: level_o=0, empty_o=1, full_o=0, maxis_tvalid_o=0, maxis_data_o=0, saxis_tready_o=1, thresh_irq_o=0, overflow_o=0.
- Reset asserted mid-transfer discards all contents immediately (asynchronous).

## Timing
- Write-to-output latency is 1 cycle: a byte accepted at edge N into an empty FIFO gives maxis_tvalid_o=1 after edge N.
- Read takes effect at the edge. The next byte, if any, is on maxis_data_o in the following cycle, so back-to-back reads sustain 1 byte/cycle.
- level_o, full_o, empty_o and thresh_irq_o are decoded combinationally from registered state. They update 1 cycle after the causing handshake.
- Pointer wrap from DEPTH−1 to 0 is transparent. level_o reaches DEPTH exactly when full.
- A simultaneous write and read at level 0 is not possible, because tvalid=0. At 0<level<DEPTH it leaves level unchanged.

## Structure
- uart_pkg holds UART_DATA_W = 8 and the default UART_RX_FIFO_DEPTH = 16, shared with the receiver and the APB register block.
- One sub-module, uart_fifo_mem: a DEPTH × DATA_W array with a synchronous write, asynchronous read, and reset to zero. Pointer, count and flag logic stays in the top module.

## Test plan
- Reset then idle: level_o=0, empty_o=1, saxis_tready_o=1, maxis_tvalid_o=0, maxis_data_o=0.
- Write 0xA5, 0x3C with maxis_tready_i=0: level_o=2, maxis_data_o=0xA5. Then assert tready for 2 cycles: the output is 0xA5 then 0x3C, then empty_o=1.
- Fill 16 bytes (0x00..0x0F), then present 0xFF: full_o=1, saxis_tready_o=0, overflow_o=1. Drain: 0x00..0x0F in order and 0xFF absent.
- At level 5, write and read in the same cycle continuously for 40 cycles (pointers wrap twice): level_o stays 5 and data order is preserved.
- thresh_i=4: thresh_irq_o rises the cycle after the 4th write and falls the cycle after the read that brings level to 3. With thresh_i=0, thresh_irq_o never asserts.
- At level 7 with overflow_o=1, pulse flush_i together with a write and a read: the next cycle shows level_o=0, overflow_o=0, empty_o=1, and the written byte is not stored.
